// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the configurable UART transmitter and the future
// uart_rx_cfg receiver. Holds the state encoding exported on the debug port,
// the parity-mode constants and helpers for divisor selection and parity.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Encoding is visible on o_Tx_SM, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_CLEANUP = 3'd5
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Widest divisor the helpers accept; callers cast to their own DIV_W.
    localparam int DIV_W_MAX = 32;

    // Widest data word the parity helper accepts (DATA_BITS tops out at 9).
    localparam int DATA_W_MAX = 9;

    // A runtime divisor of zero falls back to the elaboration-time default.
    function automatic logic [DIV_W_MAX-1:0] eff_div(
        input logic [DIV_W_MAX-1:0] div,
        input logic [DIV_W_MAX-1:0] dflt
    );
        return (div == '0) ? dflt : div;
    endfunction

    // Data is zero-padded to DATA_W_MAX; the padding does not affect the XOR.
    function automatic logic parity_bit(
        input logic [DATA_W_MAX-1:0] data,
        input int                    par_mode
    );
        return (^data) ^ (par_mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Counts clock cycles within one serial bit and strobes o_Bit_End on the last
// cycle of each bit. The counter restarts at zero on every bit boundary, so a
// divisor of 1 strobes every cycle and the counter never leaves zero.
//
// Ports:
//   i_Clock    system clock, rising edge
//   i_Reset    synchronous active-high reset
//   i_Load     restart the count at the beginning of a frame
//   i_Run      count only while a frame is on the line
//   i_Divisor  clocks per bit (must be >= 1, held stable for the frame)
//   o_Bit_End  high on the final cycle of the current bit
// -----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Load,
    input  logic             i_Run,
    input  logic [DIV_W-1:0] i_Divisor,
    output logic             o_Bit_End
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign o_Bit_End = i_Run && (cnt_q == i_Divisor - DIV_W'(1));

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
        cnt_d = cnt_q + DIV_W'(1);
        if (i_Load || !i_Run || o_Bit_End) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
// Configurable UART transmitter: DATA_BITS data bits LSB first, optional
// even/odd parity, one or two stop bits. Data and divisor are latched when a
// byte is accepted, so changes to i_Tx_Byte / i_Baud_Div mid-frame are ignored.
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Reset      synchronous active-high reset
//   i_Tx_DV      valid; byte accepted when i_Tx_DV && o_Tx_Ready
//   i_Tx_Byte    data to send
//   i_Baud_Div   runtime clocks per bit, 0 selects CLKS_PER_BIT
//   o_Tx_Ready   high in IDLE while reset is low
//   o_Tx_Active  high from the cycle after accept to the end of the last stop bit
//   o_Tx_Serial  registered serial line, idle high
//   o_Tx_Done    one-cycle pulse after the frame ends
//   o_Tx_SM      current state encoding, debug only
// -----------------------------------------------------------------------------
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DIV_W        = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    input  logic [DIV_W-1:0]     i_Baud_Div,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Done,
    output logic [2:0]           o_Tx_SM
);

    // Wide enough to index every data bit and count both stop bits.
    localparam int IDX_W = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 1 || DIV_W > DIV_W_MAX || CLKS_PER_BIT >= (64'd1 << DIV_W)) begin : g_bad_div
        $error("uart_tx_cfg: CLKS_PER_BIT must be >= 1 and fit in DIV_W bits");
    end

    uart_state_e          state_q, state_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 serial_q, serial_d;
    logic                 done_q, done_d;
    logic                 active_q, active_d;

    logic accept;
    logic load;
    logic run;
    logic bit_end;

    assign o_Tx_Ready = (state_q == ST_IDLE) && !i_Reset;
    assign accept     = i_Tx_DV && o_Tx_Ready;
    assign run        = (state_q == ST_START) || (state_q == ST_DATA) ||
                        (state_q == ST_PARITY) || (state_q == ST_STOP);

    uart_bit_timer #(
        .DIV_W (DIV_W)
    ) u_bit_timer (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_Load    (load),
        .i_Run     (run),
        .i_Divisor (div_q),
        .o_Bit_End (bit_end)
    );

    // Next-state logic. bit_idx doubles as the stop-bit counter in ST_STOP.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        div_d     = div_q;
        done_d    = 1'b0;
        active_d  = active_q;
        load      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                active_d = 1'b0;
                if (accept) begin
                    data_d    = i_Tx_Byte;
                    div_d     = DIV_W'(eff_div(DIV_W_MAX'(i_Baud_Div), DIV_W_MAX'(CLKS_PER_BIT)));
                    load      = 1'b1;
                    bit_idx_d = '0;
                    active_d  = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
                        bit_idx_d = '0;
                        done_d    = 1'b1;
                        active_d  = 1'b0;
                        state_d   = ST_CLEANUP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_CLEANUP: begin
                state_d = ST_IDLE;
            end
            default: begin
                // Unused encodings 6 and 7 recover to IDLE.
                active_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // The line is registered from the *next* state so the start bit appears
    // on the edge that accepts the byte, giving a one-cycle latency.
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = data_d[bit_idx_d];
            ST_PARITY: serial_d = parity_bit(DATA_W_MAX'(data_d), PARITY);
            default:   serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            data_q    <= '0;
            div_q     <= '0;
            serial_q  <= 1'b1;
            done_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            div_q     <= div_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
            active_q  <= active_d;
        end
    end

    assign o_Tx_Active = active_q;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Done   = done_q;
    assign o_Tx_SM     = state_q;

endmodule
